// File: rtl/kmer_pkg.sv
// Shared constants and types for the k-mer stream loader.
// No logic; types only.
// Imported by the loader interface, window and top.
package kmer_pkg;

  localparam int K         = 16;
  localparam int SEQ_LEN   = 64;
  localparam int BASE_W    = 2;
  localparam int NUM_KMERS = SEQ_LEN - K + 1;
  localparam int KMER_W    = K * BASE_W;
  localparam int CNT_W     = 7;

  typedef enum logic [BASE_W-1:0] {
    A = 2'b00,
    C = 2'b01,
    G = 2'b10,
    T = 2'b11
  } base_t;

  typedef logic [KMER_W-1:0] kmer_t;

  // Index 0 is the first window of a sequence.
  typedef kmer_t [NUM_KMERS-1:0] kmer_arr_t;

  typedef enum logic [1:0] {
    LOAD_ONE = 2'd0,
    LOAD_TWO = 2'd1,
    HOLD     = 2'd2
  } loader_state_t;

endpackage

// File: rtl/kmer_stream_loader_if.sv
// Base stream in, k-mer arrays out, between a producer and the loader.
// No logic; wiring only.
// Bases are valid/ready; arrays are held until kmersAck.
interface kmer_stream_loader_if;
  import kmer_pkg::*;

  logic [BASE_W-1:0] baseIn;
  logic              baseValid;
  logic              baseLast;
  logic              baseReady;
  kmer_arr_t         kmersSeqOne;
  kmer_arr_t         kmersSeqTwo;
  logic              kmersValid;
  logic              kmersAck;
  logic              lengthError;

  modport master (
    output baseIn, baseValid, baseLast, kmersAck,
    input  baseReady, kmersSeqOne, kmersSeqTwo, kmersValid, lengthError
  );

  modport slave (
    input  baseIn, baseValid, baseLast, kmersAck,
    output baseReady, kmersSeqOne, kmersSeqTwo, kmersValid, lengthError
  );

endinterface

// File: rtl/kmer_shift_window.sv
// Sliding 16-base window and base counter for one sequence at a time.
// k-mer/index/strobe are combinational from the accepted base (0 cycles).
// Advances only on accept; the caller owns the handshake.
module kmer_shift_window
  import kmer_pkg::*;
(
  input  logic             clk,
  input  logic             rstN,
  input  logic             accept,
  input  base_t            base_in,
  input  logic             base_last,
  output kmer_t            kmer,
  output logic [CNT_W-1:0] kmer_idx,
  output logic             kmer_wr,
  output logic             seq_done,
  output logic             len_err
);

  logic [CNT_W-1:0] base_count;
  kmer_t            window;
  logic             at_last;
  logic             full;

  assign at_last = (base_count == CNT_W'(SEQ_LEN - 1));
  assign full    = (base_count >= CNT_W'(K - 1));

  // The incoming base joins at the LSBs so the oldest base sits in the MSBs.
  assign kmer     = {window[KMER_W-BASE_W-1:0], base_in};
  assign kmer_idx = base_count - CNT_W'(K - 1);
  assign kmer_wr  = accept && full;
  assign seq_done = accept && at_last && base_last;
  // A last flag on the wrong base, or no flag on the final base, both restart.
  assign len_err  = accept && (base_last != at_last);

  // Shift window and count bases; any sequence end (good or bad) clears both.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      base_count <= '0;
      window     <= '0;
    end else if (accept) begin
      if (base_last || at_last) begin
        base_count <= '0;
        window     <= '0;
      end else begin
        base_count <= base_count + CNT_W'(1);
        window     <= kmer;
      end
    end
  end

endmodule

// File: rtl/kmer_stream_loader.sv
// Loads two base streams into 49-entry k-mer arrays for the MinHash core.
// Entry i visible 1 cycle after its accept; kmersValid 1 cycle after last base.
// baseReady low while arrays are held; released one cycle after kmersAck.
module kmer_stream_loader
  import kmer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstN,
  kmer_stream_loader_if.slave  bus
);

  loader_state_t    state;
  loader_state_t    state_nxt;
  logic             ready_en;
  logic             base_ready;
  logic             kmers_valid;
  logic             length_error;
  logic             accept;
  kmer_arr_t        seq_one;
  kmer_arr_t        seq_two;

  kmer_t            kmer;
  logic [CNT_W-1:0] kmer_idx;
  logic             kmer_wr;
  logic             seq_done;
  logic             len_err;

  assign accept = bus.baseValid && base_ready;

  kmer_shift_window u_window (
    .clk       (clk),
    .rstN      (rstN),
    .accept    (accept),
    .base_in   (base_t'(bus.baseIn)),
    .base_last (bus.baseLast),
    .kmer      (kmer),
    .kmer_idx  (kmer_idx),
    .kmer_wr   (kmer_wr),
    .seq_done  (seq_done),
    .len_err   (len_err)
  );

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= LOAD_ONE;
    else       state <= state_nxt;
  end

  // Next state: advance on a clean sequence end, leave HOLD on ack.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_ONE: if (seq_done) state_nxt = LOAD_TWO;
      LOAD_TWO: if (seq_done) state_nxt = HOLD;
      HOLD:     if (bus.kmersAck) state_nxt = LOAD_ONE;
      default:  state_nxt = LOAD_ONE;
    endcase
  end

  // Outputs from state; ready is also gated until the first clock after reset.
  always_comb begin
    base_ready  = 1'b0;
    kmers_valid = 1'b0;
    case (state)
      LOAD_ONE, LOAD_TWO: base_ready  = ready_en;
      HOLD:               kmers_valid = 1'b1;
      default:            base_ready  = 1'b0;
    endcase
  end

  // Keeps every output low while in reset and during the release cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Single-cycle error pulse following the offending accept.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) length_error <= 1'b0;
    else       length_error <= len_err;
  end

  // Write the completed window into the array of the sequence being loaded.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      seq_one <= '0;
      seq_two <= '0;
    end else if (kmer_wr) begin
      for (int i = 0; i < NUM_KMERS; i++) begin
        if (kmer_idx == CNT_W'(i)) begin
          if (state == LOAD_ONE) seq_one[i] <= kmer;
          else                   seq_two[i] <= kmer;
        end
      end
    end
  end

  assign bus.baseReady   = base_ready;
  assign bus.kmersValid  = kmers_valid;
  assign bus.lengthError = length_error;
  assign bus.kmersSeqOne = seq_one;
  assign bus.kmersSeqTwo = seq_two;

endmodule
